// File: rtl/pipe_ctrl.sv
//==============================================================================
// Module      : pipe_ctrl
// Description : Five-stage pipeline hazard controller. It issues per-register
//               stall/bubble commands and keeps a sticky memory-wait timeout.
//               Optional performance counters are built under PIPE_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef CTRL_Wire_Bus
`define CTRL_Wire_Bus 1:0
`endif
`ifndef CTRL_STATE_Default
`define CTRL_STATE_Default 2'b00
`endif
`ifndef CTRL_STATE_Stalled
`define CTRL_STATE_Stalled 2'b01
`endif
`ifndef CTRL_STATE_Bubble
`define CTRL_STATE_Bubble 2'b10
`endif

module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             ex_opcode_i,
    input  logic [4:0]             ex_rd_addr_i,
    input  logic                   ex_wreg_i,
    input  logic [4:0]             id_rs1_addr_i,
    input  logic [4:0]             id_rs2_addr_i,
    input  logic                   id_rs1_use_i,
    input  logic                   id_rs2_use_i,
    input  logic                   branch_taken_i,
    input  logic                   mem_req_i,
    input  logic                   mem_ready_i,
    output logic [`CTRL_Wire_Bus]  pc_ctrl_o,
    output logic [`CTRL_Wire_Bus]  if_id_ctrl_o,
    output logic [`CTRL_Wire_Bus]  id_ex_ctrl_o,
    output logic [`CTRL_Wire_Bus]  ex_mem_ctrl_o,
    output logic [`CTRL_Wire_Bus]  mem_wb_ctrl_o,
    output logic                   mem_timeout_o,
    output logic [CNT_W-1:0]       stall_cnt_o,
    output logic [CNT_W-1:0]       flush_cnt_o,
    output logic [CNT_W-1:0]       lu_cnt_o
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_FLUSH    = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [6:0] c_op_load = 7'b0000011;
    localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_flush_pend;
    logic       w_flush_pend_nxt;
    logic [7:0] r_wait_cnt;
    logic       r_mem_timeout;
    logic       w_mem_wait;
    logic       w_load_use;

    assign w_mem_wait = mem_req_i && !mem_ready_i;
    assign w_load_use = (ex_opcode_i == c_op_load) && ex_wreg_i && (ex_rd_addr_i != 5'd0) &&
                        ((id_rs1_use_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                         (id_rs2_use_i && (id_rs2_addr_i == ex_rd_addr_i)));

    always_comb begin
        pc_ctrl_o        = `CTRL_STATE_Default;
        if_id_ctrl_o     = `CTRL_STATE_Default;
        id_ex_ctrl_o     = `CTRL_STATE_Default;
        ex_mem_ctrl_o    = `CTRL_STATE_Default;
        mem_wb_ctrl_o    = `CTRL_STATE_Default;
        w_state_nxt      = r_state;
        w_flush_pend_nxt = r_flush_pend;

        if (!rst) begin
            if (w_mem_wait) begin
                pc_ctrl_o     = `CTRL_STATE_Stalled;
                if_id_ctrl_o  = `CTRL_STATE_Stalled;
                id_ex_ctrl_o  = `CTRL_STATE_Stalled;
                ex_mem_ctrl_o = `CTRL_STATE_Stalled;
                mem_wb_ctrl_o = `CTRL_STATE_Bubble;
            end else if (branch_taken_i) begin
                if_id_ctrl_o  = `CTRL_STATE_Bubble;
                id_ex_ctrl_o  = `CTRL_STATE_Bubble;
            end else if (r_state == S_FLUSH) begin
                if_id_ctrl_o  = `CTRL_STATE_Bubble;
            end else if (w_load_use) begin
                pc_ctrl_o     = `CTRL_STATE_Stalled;
                if_id_ctrl_o  = `CTRL_STATE_Stalled;
                id_ex_ctrl_o  = `CTRL_STATE_Bubble;
            end
        end

        // A branch seen while memory stalls is dropped; EX re-presents it later.
        case (r_state)
            S_RUN: begin
                if (w_mem_wait) begin
                    w_state_nxt = S_MEM_WAIT;
                end else if (branch_taken_i) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_mem_wait) begin
                    w_state_nxt      = S_MEM_WAIT;
                    w_flush_pend_nxt = 1'b1;
                end else if (branch_taken_i) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_MEM_WAIT: begin
                if (!w_mem_wait) begin
                    w_state_nxt      = (branch_taken_i || r_flush_pend) ? S_FLUSH : S_RUN;
                    w_flush_pend_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt      = S_RUN;
                w_flush_pend_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_flush_pend  <= 1'b0;
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_pend <= w_flush_pend_nxt;
            if (w_mem_wait) begin
                if (r_wait_cnt != c_timeout) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
                if (r_wait_cnt >= (c_timeout - 8'd1)) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= 8'd0;
            end
        end
    end

    assign mem_timeout_o = r_mem_timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic             w_redirect;
    logic             w_lu_bubble;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_lu_cnt;

    assign w_redirect  = branch_taken_i && !w_mem_wait;
    assign w_lu_bubble = w_load_use && !w_mem_wait && !branch_taken_i && (r_state != S_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_lu_cnt    <= '0;
        end else begin
            if (w_mem_wait)  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_redirect)  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if (w_lu_bubble) r_lu_cnt    <= r_lu_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
    assign lu_cnt_o    = r_lu_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
    assign lu_cnt_o    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
//==============================================================================
// Module      : tb_pipe_ctrl
// Description : Scoreboard bench for pipe_ctrl: directed scenarios followed by
//               random traffic against an event-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef CTRL_Wire_Bus
`define CTRL_Wire_Bus 1:0
`endif
`ifndef CTRL_STATE_Default
`define CTRL_STATE_Default 2'b00
`endif
`ifndef CTRL_STATE_Stalled
`define CTRL_STATE_Stalled 2'b01
`endif
`ifndef CTRL_STATE_Bubble
`define CTRL_STATE_Bubble 2'b10
`endif

module tb_pipe_ctrl;

    localparam int TO = 4;
    localparam int CW = 32;
    localparam logic [1:0] D = `CTRL_STATE_Default;
    localparam logic [1:0] S = `CTRL_STATE_Stalled;
    localparam logic [1:0] B = `CTRL_STATE_Bubble;

    logic clk;
    logic rst;
    logic [6:0] ex_opcode;
    logic [4:0] ex_rd, rs1, rs2;
    logic ex_wreg, use1, use2, br, mreq, mrdy;
    logic [`CTRL_Wire_Bus] pc_c, ifid_c, idex_c, exmem_c, memwb_c;
    logic mem_to;
    logic [CW-1:0] stall_cnt, flush_cnt, lu_cnt;

    pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ex_opcode_i(ex_opcode), .ex_rd_addr_i(ex_rd), .ex_wreg_i(ex_wreg),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .id_rs1_use_i(use1), .id_rs2_use_i(use2),
        .branch_taken_i(br), .mem_req_i(mreq), .mem_ready_i(mrdy),
        .pc_ctrl_o(pc_c), .if_id_ctrl_o(ifid_c), .id_ex_ctrl_o(idex_c),
        .ex_mem_ctrl_o(exmem_c), .mem_wb_ctrl_o(memwb_c),
        .mem_timeout_o(mem_to),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .lu_cnt_o(lu_cnt)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [9:0]    ctrl;
        logic          to;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        logic [CW-1:0] lc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model: pipeline-level events rather than controller states.
    bit            m_kill_now  = 0;   // this cycle must kill the stale fetch
    bit            m_in_wait   = 0;   // previous cycle was a memory stall
    bit            m_owed      = 0;   // a kill was interrupted by a stall
    int            m_run       = 0;
    bit            m_to        = 0;
    logic [CW-1:0] m_sc = '0, m_fc = '0, m_lc = '0;

    function automatic bit f_lu();
        return (ex_opcode == 7'b0000011) && ex_wreg && (ex_rd != 5'd0) &&
               ((use1 && rs1 == ex_rd) || (use2 && rs2 == ex_rd));
    endfunction

    task automatic set_in(input bit r, input bit mq, input bit mr, input bit b,
                          input logic [6:0] op, input logic [4:0] rd, input bit wr,
                          input logic [4:0] a1, input logic [4:0] a2,
                          input bit u1, input bit u2);
        rst = r; mreq = mq; mrdy = mr; br = b; ex_opcode = op; ex_rd = rd;
        ex_wreg = wr; rs1 = a1; rs2 = a2; use1 = u1; use2 = u2;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 7'h13, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    endtask

    task automatic step();
        exp_t e;
        bit mw, lu, kill_eff, lu_eff;
        mw       = mreq && !mrdy;
        lu       = f_lu();
        kill_eff = m_kill_now && !mw && !br;
        lu_eff   = lu && !mw && !br && !m_kill_now;
        if (rst)           e.ctrl = {D, D, D, D, D};
        else if (mw)       e.ctrl = {S, S, S, S, B};
        else if (br)       e.ctrl = {D, B, B, D, D};
        else if (kill_eff) e.ctrl = {D, B, D, D, D};
        else if (lu_eff)   e.ctrl = {S, S, B, D, D};
        else               e.ctrl = {D, D, D, D, D};
        e.to = m_to;
`ifdef PIPE_CTRL_PERF_EN
        e.sc = m_sc; e.fc = m_fc; e.lc = m_lc;
`else
        e.sc = '0; e.fc = '0; e.lc = '0;
`endif
        q.push_back(e);
        @(posedge clk);
        if (rst) begin
            m_kill_now = 0; m_in_wait = 0; m_owed = 0;
            m_run = 0; m_to = 0; m_sc = '0; m_fc = '0; m_lc = '0;
        end else begin
            if (mw) m_sc = m_sc + 1;
            if (br && !mw) m_fc = m_fc + 1;
            if (lu_eff && !rst) m_lc = m_lc + 1;
            if (mw) begin
                if (m_run < TO) m_run = m_run + 1;
                if (m_run >= TO) m_to = 1;
            end else begin
                m_run = 0;
            end
            begin
                bit nk, no;
                nk = !mw && (br || (m_in_wait && m_owed));
                no = mw ? (m_owed || m_kill_now) : 1'b0;
                m_kill_now = nk;
                m_owed     = no;
                m_in_wait  = mw;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        exp_t e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pc_c, ifid_c, idex_c, exmem_c, memwb_c};
                tests++;
                if (act !== e.ctrl) begin
                    fails++;
                    $display("FAIL ctrl cyc=%0d actual=%h required=%h", cyc, act, e.ctrl);
                end
                tests++;
                if (mem_to !== e.to) begin
                    fails++;
                    $display("FAIL timeout cyc=%0d actual=%b required=%b", cyc, mem_to, e.to);
                end
                tests++;
                if ({stall_cnt, flush_cnt, lu_cnt} !== {e.sc, e.fc, e.lc}) begin
                    fails++;
                    $display("FAIL counters cyc=%0d actual=%0d/%0d/%0d required=%0d/%0d/%0d",
                             cyc, stall_cnt, flush_cnt, lu_cnt, e.sc, e.fc, e.lc);
                end
            end
        end
    end

    initial begin
        int hold;
        idle(); rst = 1;
        step(); step();
        // load-use on rs1
        set_in(0, 0, 0, 0, 7'b0000011, 5'd5, 1, 5'd5, 5'd0, 1, 0); step();
        idle(); step(); step();
        // single branch in RUN
        idle(); br = 1; step();
        idle(); step(); step();
        // branch then three memory-stall cycles
        idle(); br = 1; step();
        repeat (3) begin idle(); mreq = 1; step(); end
        idle(); step(); step(); step();
        // timeout: six stall cycles, then idle
        repeat (6) begin idle(); mreq = 1; step(); end
        repeat (3) begin idle(); step(); end
        // load-use together with branch
        set_in(0, 0, 0, 1, 7'b0000011, 5'd7, 1, 5'd0, 5'd7, 0, 1); step();
        idle(); step(); step();
        // reset during a stall with a flush pending
        idle(); br = 1; step();
        idle(); mreq = 1; step();
        idle(); mreq = 1; rst = 1; step();
        idle(); step(); step();
        // random traffic
        hold = 0;
        for (int i = 0; i < 800; i++) begin
            set_in(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 4),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 15),
                   ($urandom_range(0, 1) == 1) ? 7'b0000011 : 7'($urandom_range(0, 127)),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
            if (hold == 0 && $urandom_range(0, 49) == 0) hold = $urandom_range(3, 7);
            if (hold > 0) begin
                mreq = 1; mrdy = 0; hold--;
            end
            step();
        end
        idle(); step();
        @(negedge clk); #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: number of consecutive MEM_WAIT cycles after which the timeout flag sets; range 1..255.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ex_opcode_i  input  7  opcode of the instruction currently in EX.
REQ-006 ex_rd_addr_i  input  5  destination register of the EX instruction.
REQ-007 ex_wreg_i  input  1  EX instruction writes rd.
REQ-008 id_rs1_addr_i, id_rs2_addr_i  input  5 each  source registers of the ID instruction.
REQ-009 id_rs1_use_i, id_rs2_use_i  input  1 each  ID instruction reads rs1 / rs2.
REQ-010 branch_taken_i  input  1  EX resolved a taken branch or jump this cycle.
REQ-011 mem_req_i  input  1  MEM stage has an outstanding data access.
REQ-012 mem_ready_i  input  1  data access completes this cycle.
REQ-013 pc_ctrl_o, if_id_ctrl_o, id_ex_ctrl_o, ex_mem_ctrl_o, mem_wb_ctrl_o  output  `CTRL_Wire_Bus each  per-register command using CTRL_STATE_Default / CTRL_STATE_Stalled / CTRL_STATE_Bubble from defines.v.
REQ-014 mem_timeout_o  output  1  sticky memory-wait timeout flag.
REQ-015 stall_cnt_o, flush_cnt_o, lu_cnt_o  output  CNT_W each  performance counters.

Function
REQ-016 Ctrl outputs SHALL be combinational from the current state and inputs, valid in the same cycle, with zero latency.
REQ-017 mem_wait = mem_req_i && !mem_ready_i; load_use = (ex_opcode_i == 7'b0000011) && ex_wreg_i && ex_rd_addr_i != 0 && ((id_rs1_use_i && id_rs1_addr_i == ex_rd_addr_i) || (id_rs2_use_i && id_rs2_addr_i == ex_rd_addr_i)).
REQ-018 Per-cycle priority SHALL be mem_wait > branch_taken_i > FLUSH-state kill > load_use > normal.
REQ-019 mem_wait: pc, if_id, id_ex, ex_mem = Stalled; mem_wb = Bubble.
REQ-020 branch_taken_i without mem_wait: pc = Default; if_id, id_ex = Bubble; ex_mem, mem_wb = Default.
REQ-021 load_use alone: pc, if_id = Stalled; id_ex = Bubble; ex_mem, mem_wb = Default.
REQ-022 Normal: all five outputs Default.
REQ-023 States RUN, FLUSH, MEM_WAIT; one flag flush_pend.
REQ-024 RUN: mem_wait -> MEM_WAIT; else branch_taken_i -> FLUSH; else stay in RUN.
REQ-025 FLUSH (one cycle, kills the stale fetch behind a redirect): if_id = Bubble, others Default unless a higher priority applies; mem_wait -> MEM_WAIT with flush_pend set; branch_taken_i -> FLUSH; else -> RUN.
REQ-026 MEM_WAIT: stay while mem_wait; on exit, branch_taken_i or flush_pend -> FLUSH (flush_pend cleared), else -> RUN.
REQ-027 A branch_taken_i arriving during mem_wait SHALL be ignored; EX is stalled and the branch reasserts after release.
REQ-028 The wait counter SHALL count consecutive mem_wait cycles, saturate at MEM_TIMEOUT, and clear when mem_wait is low; reaching MEM_TIMEOUT sets mem_timeout_o, which holds until rst.

Reset
REQ-029 While rst = 1, all ctrl outputs SHALL be Default.
REQ-030 On the rst edge: state = RUN, flush_pend = 0, wait counter = 0, mem_timeout_o = 0, all performance counters = 0. Reset mid-MEM_WAIT or mid-FLUSH SHALL abandon the pending flush.

Configuration
REQ-031 Macro PIPE_CTRL_PERF_EN defined: stall_cnt_o counts mem_wait cycles, flush_cnt_o counts branch_taken_i redirects, lu_cnt_o counts load_use bubbles; each counter wraps modulo 2^CNT_W.
REQ-032 Macro PIPE_CTRL_PERF_EN undefined: counters are not built; the three ports stay present and are tied to 0.

Verification
REQ-033 ld x5 in EX, ID reads x5 via rs1 -> one cycle of pc/if_id Stalled with id_ex Bubble, then all Default; lu_cnt_o = 1.
REQ-034 branch_taken_i for 1 cycle in RUN -> cycle N: if_id/id_ex Bubble; cycle N+1: FLUSH with if_id Bubble; cycle N+2: RUN, all Default; flush_cnt_o = 1.
REQ-035 Branch at cycle N, then mem_wait for 3 cycles from N+1 -> 3 cycles of MEM_WAIT outputs, then FLUSH kill on release, then RUN; stall_cnt_o = 3.
REQ-036 MEM_TIMEOUT = 4, mem_wait held for 6 cycles -> mem_timeout_o rises after the 4th cycle and stays 1 after release until rst.
REQ-037 load_use and branch_taken_i asserted together -> branch outputs only; lu_cnt_o unchanged.
REQ-038 rst asserted during MEM_WAIT with flush_pend = 1 -> next cycle is RUN, all outputs Default, counters 0, no FLUSH cycle.
